// File: rtl/intr_ctrl_if.sv
// Interrupt controller bus: request lines and control-unit strobes in,
// dispatch pulses and status out.
interface intr_ctrl_if;
    logic       irq1_in;
    logic       irq2_in;
    logic       timer_tick;
    logic       reti;
    logic       mask_we;
    logic [1:0] mask_d;
    logic       clr_we;
    logic [1:0] clr_d;
    logic       s_intr1;
    logic       s_intr2;
    logic       in_service;
    logic [1:0] pending;
    logic [1:0] mask;

    modport master (
        output irq1_in, irq2_in, timer_tick, reti,
        output mask_we, mask_d, clr_we, clr_d,
        input  s_intr1, s_intr2, in_service, pending, mask
    );

    modport slave (
        input  irq1_in, irq2_in, timer_tick, reti,
        input  mask_we, mask_d, clr_we, clr_d,
        output s_intr1, s_intr2, in_service, pending, mask
    );
endinterface

// File: rtl/intr_ctrl.sv
// Two-line interrupt controller: synchronises and latches requests as pending,
// masks/prioritises them and issues one-cycle dispatch pulses, blocking until reti.
module intr_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE_MODE   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    intr_ctrl_if.slave  bus
);

    localparam int unsigned NLINES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        ISR  = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sync1_q, sync1_d;
    logic [SYNC_STAGES-1:0] sync2_q, sync2_d;
    logic [NLINES-1:0]      prev_q, prev_d;
    logic [NLINES-1:0]      pending_q, pending_d;
    logic [NLINES-1:0]      mask_q, mask_d;
    logic [NLINES-1:0]      req_lvl;
    logic [NLINES-1:0]      req_set;
    logic [NLINES-1:0]      disp_clr;
    logic [NLINES-1:0]      sw_clr;
    logic [NLINES-1:0]      enabled;
    state_e                 state_q, state_d;
    logic                   s_intr1_q, s_intr1_d;
    logic                   s_intr2_q, s_intr2_d;
    logic                   in_service_q, in_service_d;

    // Request capture: synchronisers, edge/level detect, timer merges onto line 2
    always_comb begin
        sync1_d = {sync1_q[SYNC_STAGES-2:0], bus.irq1_in};
        sync2_d = {sync2_q[SYNC_STAGES-2:0], bus.irq2_in};
        req_lvl = {sync2_q[SYNC_STAGES-1], sync1_q[SYNC_STAGES-1]};
        prev_d  = req_lvl;
        if (EDGE_MODE) begin
            req_set = req_lvl & ~prev_q;
        end else begin
            req_set = req_lvl;
        end
        req_set = req_set | {bus.timer_tick, 1'b0};
    end

    // Pending and mask: a new set always wins over any clear in the same cycle
    always_comb begin
        sw_clr    = bus.clr_we ? bus.clr_d : NLINES'(0);
        pending_d = (pending_q & ~(disp_clr | sw_clr)) | req_set;
        mask_d    = bus.mask_we ? bus.mask_d : mask_q;
    end

    // Dispatch FSM; decisions use the registered pending and mask
    always_comb begin
        state_d      = state_q;
        disp_clr     = '0;
        s_intr1_d    = 1'b0;
        s_intr2_d    = 1'b0;
        in_service_d = in_service_q;
        enabled      = pending_q & mask_q;

        unique case (state_q)
            IDLE: begin
                in_service_d = 1'b0;
                if (enabled[0]) begin
                    disp_clr     = NLINES'(1);
                    s_intr1_d    = 1'b1;
                    in_service_d = 1'b1;
                    state_d      = FIRE;
                end else if (enabled[1]) begin
                    disp_clr     = NLINES'(2);
                    s_intr2_d    = 1'b1;
                    in_service_d = 1'b1;
                    state_d      = FIRE;
                end
            end
            FIRE: begin
                in_service_d = 1'b1;
                state_d      = ISR;
            end
            ISR: begin
                in_service_d = 1'b1;
                if (bus.reti) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                in_service_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            state_q      <= IDLE;
            s_intr1_q    <= 1'b0;
            s_intr2_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            state_q      <= state_d;
            s_intr1_q    <= s_intr1_d;
            s_intr2_q    <= s_intr2_d;
            in_service_q <= in_service_d;
        end
    end

    assign bus.s_intr1    = s_intr1_q;
    assign bus.s_intr2    = s_intr2_q;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;
    assign bus.mask       = mask_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: expected dispatch pulses (line, cycle) are
// queued as stimulus is applied and matched against every observed pulse.
module tb_intr_ctrl;

    localparam int unsigned SYNC_STAGES = 2;

    typedef struct {
        logic [1:0] line;
        int         at;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    intr_ctrl_if bus_if();

    intr_ctrl #(
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_MODE  (1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [1:0] line, input int at);
        exp_t e;
        e.line = line;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic do_reti();
        bus_if.reti = 1'b1;
        step(1);
        bus_if.reti = 1'b0;
    endtask

    // Pulse monitor: every observed pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && (bus_if.s_intr1 === 1'b1 || bus_if.s_intr2 === 1'b1)) begin
            chk("pulse_onehot", 32'(bus_if.s_intr1 & bus_if.s_intr2), 32'h0);
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", 32'({bus_if.s_intr2, bus_if.s_intr1}), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_line", 32'({bus_if.s_intr2, bus_if.s_intr1}), 32'(e.line));
                chk("pulse_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    initial begin
        int c0;
        int r;
        int w;
        int t;

        reset             = 1'b0;
        bus_if.irq1_in    = 1'b1;
        bus_if.irq2_in    = 1'b0;
        bus_if.timer_tick = 1'b0;
        bus_if.reti       = 1'b0;
        bus_if.mask_we    = 1'b0;
        bus_if.mask_d     = 2'b00;
        bus_if.clr_we     = 1'b0;
        bus_if.clr_d      = 2'b00;

        // Reset with irq1 held, then release with mask enabled
        step(3);
        chk("rst_s_intr1", 32'(bus_if.s_intr1), 32'h0);
        chk("rst_s_intr2", 32'(bus_if.s_intr2), 32'h0);
        chk("rst_in_service", 32'(bus_if.in_service), 32'h0);
        chk("rst_pending", 32'(bus_if.pending), 32'h0);
        chk("rst_mask", 32'(bus_if.mask), 32'h0);
        c0 = cyc;
        expect_pulse(2'b01, c0 + int'(SYNC_STAGES) + 2);
        reset          = 1'b1;
        bus_if.mask_we = 1'b1;
        bus_if.mask_d  = 2'b11;
        step(1);
        bus_if.mask_we = 1'b0;
        chk("t1_mask", 32'(bus_if.mask), 32'h3);
        step(SYNC_STAGES + 1);
        chk("t1_in_service", 32'(bus_if.in_service), 32'h1);
        chk("t1_pending", 32'(bus_if.pending), 32'h0);
        step(2);
        chk("t1_isr_hold", 32'(bus_if.in_service), 32'h1);
        do_reti();
        chk("t1_reti_exit", 32'(bus_if.in_service), 32'h0);
        bus_if.irq1_in = 1'b0;
        step(SYNC_STAGES + 3);

        // Simultaneous edges: line 1 first, line 2 two cycles after reti
        c0 = cyc;
        expect_pulse(2'b01, c0 + int'(SYNC_STAGES) + 2);
        bus_if.irq1_in = 1'b1;
        bus_if.irq2_in = 1'b1;
        step(SYNC_STAGES + 2);
        chk("t2_pending_after_l1", 32'(bus_if.pending), 32'h2);
        step(3);
        chk("t2_pending_in_isr", 32'(bus_if.pending), 32'h2);
        chk("t2_in_service", 32'(bus_if.in_service), 32'h1);
        r = cyc;
        expect_pulse(2'b10, r + 2);
        do_reti();
        step(1);
        chk("t2_pending_after_l2", 32'(bus_if.pending), 32'h0);
        chk("t2_in_service_l2", 32'(bus_if.in_service), 32'h1);
        bus_if.irq1_in = 1'b0;
        bus_if.irq2_in = 1'b0;
        step(2);
        do_reti();
        step(SYNC_STAGES + 3);

        // Masked timer request waits, then dispatches once unmasked
        bus_if.mask_we = 1'b1;
        bus_if.mask_d  = 2'b01;
        step(1);
        bus_if.mask_we    = 1'b0;
        bus_if.timer_tick = 1'b1;
        step(1);
        bus_if.timer_tick = 1'b0;
        chk("t3_timer_pending", 32'(bus_if.pending), 32'h2);
        step(3);
        chk("t3_masked_idle", 32'(bus_if.in_service), 32'h0);
        chk("t3_masked_pending", 32'(bus_if.pending), 32'h2);
        w = cyc;
        expect_pulse(2'b10, w + 2);
        bus_if.mask_we = 1'b1;
        bus_if.mask_d  = 2'b10;
        step(1);
        bus_if.mask_we = 1'b0;
        step(1);
        chk("t3_in_service", 32'(bus_if.in_service), 32'h1);
        chk("t3_pending_clr", 32'(bus_if.pending), 32'h0);

        // Ticks during ISR collapse into one pending request
        repeat (3) begin
            bus_if.timer_tick = 1'b1;
            step(1);
            bus_if.timer_tick = 1'b0;
            step(1);
        end
        chk("t4_pending_once", 32'(bus_if.pending), 32'h2);
        chk("t4_in_service", 32'(bus_if.in_service), 32'h1);
        r = cyc;
        expect_pulse(2'b10, r + 2);
        do_reti();
        step(1);
        chk("t4_pending_taken", 32'(bus_if.pending), 32'h0);
        step(2);
        repeat (3) begin
            bus_if.timer_tick = 1'b1;
            step(1);
            bus_if.timer_tick = 1'b0;
            step(1);
        end
        chk("t4_pending_again", 32'(bus_if.pending), 32'h2);
        bus_if.clr_we = 1'b1;
        bus_if.clr_d  = 2'b10;
        step(1);
        bus_if.clr_we = 1'b0;
        bus_if.clr_d  = 2'b00;
        chk("t4_sw_clear", 32'(bus_if.pending), 32'h0);
        do_reti();
        step(4);
        chk("t4_idle_no_pulse", 32'(bus_if.in_service), 32'h0);

        // Timer set in the same cycle as the line-2 dispatch clear survives
        t = cyc;
        expect_pulse(2'b10, t + 2);
        bus_if.timer_tick = 1'b1;
        step(1);
        chk("t5_pending_set", 32'(bus_if.pending), 32'h2);
        step(1);
        bus_if.timer_tick = 1'b0;
        chk("t5_set_beats_clear", 32'(bus_if.pending), 32'h2);
        chk("t5_in_service", 32'(bus_if.in_service), 32'h1);
        step(2);
        r = cyc;
        expect_pulse(2'b10, r + 2);
        do_reti();
        step(1);
        chk("t5_second_taken", 32'(bus_if.pending), 32'h0);
        step(2);
        do_reti();
        step(3);

        // Reset asserted while the line-2 pulse is high
        t = cyc;
        expect_pulse(2'b10, t + 2);
        bus_if.timer_tick = 1'b1;
        step(1);
        bus_if.timer_tick = 1'b0;
        step(1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_pulse_drop", 32'(bus_if.s_intr2), 32'h0);
        chk("t6_in_service", 32'(bus_if.in_service), 32'h0);
        chk("t6_pending", 32'(bus_if.pending), 32'h0);
        chk("t6_mask", 32'(bus_if.mask), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(5);
        chk("t6_post_in_service", 32'(bus_if.in_service), 32'h0);
        chk("t6_post_pending", 32'(bus_if.pending), 32'h0);

        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("missing_pulse", 32'(e.at), 32'hFFFF_FFFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
